render_cell_rect: RTL

- Parametrised successor to the single-box renderer.
- Rasterises a rectangle of n_cols x n_rows Tetris cells (CELL_W x CELL_H pixels each) at a pixel origin, in one of three fill modes.
- Emits a pixel-write stream with valid/ready backpressure, so it can sit behind an arbiter in front of the shared VGA adapter instead of owning one.
- Clips pixels that fall off-screen; used to draw cells, clear the board, and draw bordered panels.

---
 rtl/render_cell_rect_pkg.sv | 23 ++
 rtl/render_cell_rect_if.sv | 24 ++
 rtl/render_cell_rect_scan_axis_counter.sv | 37 +++
 rtl/render_cell_rect.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/render_cell_rect_pkg.sv
// rtl/render_cell_rect_pkg.sv - shared encodings and defaults for the cell rectangle renderer
package render_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID     = 2'd0,
    MODE_BORDERED  = 2'd1,
    MODE_OUTLINE   = 2'd2,
    MODE_SOLID_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_CELL_W   = 24;
  localparam int DEF_CELL_H   = 24;
  localparam int DEF_BORDER   = 1;

endpackage

// File: rtl/render_cell_rect_if.sv
// rtl/render_cell_rect_if.sv - pixel write stream between renderer and VGA arbiter
interface render_cell_rect_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 9
);

  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_valid;
  logic               pix_ready;

  modport master (
    output pix_x, pix_y, pix_color, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_x, pix_y, pix_color, pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/render_cell_rect_scan_axis_counter.sv
// rtl/render_cell_rect_scan_axis_counter.sv - one raster axis: global offset plus cell-local offset
module scan_axis_counter #(
  parameter int GW   = 11,
  parameter int LW   = 5,
  parameter int CELL = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [GW-1:0] g_max,
  output logic [GW-1:0] g,
  output logic [LW-1:0] l,
  output logic          last,
  output logic          wrap
);

  assign last = (g == g_max);
  assign wrap = (l == LW'(CELL - 1));

  // Local offset wraps by compare, so no divider is ever needed
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      g <= '0;
      l <= '0;
    end else if (en) begin
      if (last) begin
        g <= '0;
        l <= '0;
      end else begin
        g <= g + 1'b1;
        l <= wrap ? '0 : l + 1'b1;
      end
    end
  end

endmodule

// File: rtl/render_cell_rect.sv
// rtl/render_cell_rect.sv - rasterises an n_cols x n_rows block of cells onto a pixel write stream
module render_cell_rect
  import render_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int COLOR_W  = 9,
  parameter int CELL_W   = DEF_CELL_W,
  parameter int CELL_H   = DEF_CELL_H,
  parameter int BORDER   = DEF_BORDER,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int COLS_W   = 4,
  parameter int ROWS_W   = 5
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [COLS_W-1:0]  n_cols,
  input  logic [ROWS_W-1:0]  n_rows,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] fill_color,
  input  logic [COLOR_W-1:0] border_color,
  output logic               busy,
  output logic               done,
  render_cell_rect_if.master pix
);

  localparam int GXW = X_W + 1;
  localparam int GYW = Y_W + 1;
  localparam int LXW = $clog2(CELL_W);
  localparam int LYW = $clog2(CELL_H);

  state_e state, state_nx;

  logic [X_W-1:0]     x0_r;
  logic [Y_W-1:0]     y0_r;
  logic [GXW-1:0]     x_max;
  logic [GYW-1:0]     y_max;
  mode_e              mode_r;
  logic [COLOR_W-1:0] fill_r;
  logic [COLOR_W-1:0] border_r;

  logic [GXW-1:0] gx;
  logic [GYW-1:0] gy;
  logic [LXW-1:0] lx;
  logic [LYW-1:0] ly;
  logic           x_last, x_wrap, y_last, y_wrap;

  logic           accept, zero_size, drawing, advance, row_end, final_px;
  logic           is_border, clipped, mode_hide, suppress;
  logic [GXW-1:0] sum_x;
  logic [GYW-1:0] sum_y;
  logic [COLOR_W-1:0] color_sel;

  assign accept    = (state == ST_IDLE) && start;
  assign zero_size = (n_cols == '0) || (n_rows == '0);
  assign drawing   = (state == ST_DRAW);

  // Spans are whole cells, so the global end of a row always lands on a local wrap
  assign advance  = drawing && (suppress || pix.pix_ready);
  assign row_end  = advance && x_last && x_wrap;
  assign final_px = row_end && y_last && y_wrap;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x0_r     <= '0;
      y0_r     <= '0;
      x_max    <= '0;
      y_max    <= '0;
      mode_r   <= MODE_SOLID;
      fill_r   <= '0;
      border_r <= '0;
    end else if (accept) begin
      x0_r     <= x0;
      y0_r     <= y0;
      x_max    <= GXW'(int'(n_cols) * CELL_W - 1);
      y_max    <= GYW'(int'(n_rows) * CELL_H - 1);
      mode_r   <= mode_e'(mode);
      fill_r   <= fill_color;
      border_r <= border_color;
    end
  end

  scan_axis_counter #(.GW(GXW), .LW(LXW), .CELL(CELL_W)) u_x_axis (
    .clk   (CLOCK_50),
    .reset (reset),
    .clr   (accept),
    .en    (advance),
    .g_max (x_max),
    .g     (gx),
    .l     (lx),
    .last  (x_last),
    .wrap  (x_wrap)
  );

  scan_axis_counter #(.GW(GYW), .LW(LYW), .CELL(CELL_H)) u_y_axis (
    .clk   (CLOCK_50),
    .reset (reset),
    .clr   (accept),
    .en    (row_end),
    .g_max (y_max),
    .g     (gy),
    .l     (ly),
    .last  (y_last),
    .wrap  (y_wrap)
  );

  assign is_border = (lx < LXW'(BORDER)) || (lx >= LXW'(CELL_W - BORDER)) ||
                     (ly < LYW'(BORDER)) || (ly >= LYW'(CELL_H - BORDER));

  assign sum_x   = {1'b0, x0_r} + gx;
  assign sum_y   = {1'b0, y0_r} + gy;
  assign clipped = (sum_x >= GXW'(SCREEN_W)) || (sum_y >= GYW'(SCREEN_H));

  always_comb begin
    color_sel = fill_r;
    mode_hide = 1'b0;
    case (mode_r)
      MODE_BORDERED: if (is_border) color_sel = border_r;
      MODE_OUTLINE: begin
        color_sel = border_r;
        mode_hide = !is_border;
      end
      default: color_sel = fill_r;
    endcase
  end

  assign suppress = clipped || mode_hide;

  assign pix.pix_valid = drawing && !suppress;
  assign pix.pix_x     = drawing ? sum_x[X_W-1:0] : '0;
  assign pix.pix_y     = drawing ? sum_y[Y_W-1:0] : '0;
  assign pix.pix_color = drawing ? color_sel : '0;

  assign busy = drawing;
  assign done = (state == ST_DONE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = zero_size ? ST_DONE : ST_DRAW;
      ST_DRAW: if (final_px) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
